// File: rtl/branch_ctrl_pkg.sv
// Shared types and helpers for the fetch PC / redirect controller.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        TRAP   = 2'd3
    } state_t;

    localparam int PC_STEP = 4;

    // A target is unusable if it is not word aligned or lies beyond instruction memory.
    function automatic logic tgt_bad(input logic [31:0] tgt, input int pc_w);
        logic high_bits;
        high_bits = (pc_w < 32) ? ((tgt >> pc_w) != 32'd0) : 1'b0;
        return (tgt[1:0] != 2'b00) || high_bits;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Fetch PC owner: sequential/redirect/hold selection, younger-stage flushes,
// halt drain, sticky bad-target trap and branch statistics.
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_is_ctrl,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             fetch_en,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam int DRN_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRN_W-1:0] DRN_RELOAD = DRN_W'(DRAIN_CYC - 1);

    state_t           state, state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [DRN_W-1:0] drn_cnt, drn_nxt;
    logic             trap_nxt;
    logic             active, redirect, bad_tgt, flush;
    logic             br_inc, taken_inc;

    assign active    = (state == RUN) || (state == DRAIN);
    assign redirect  = active && ex_valid && ex_is_ctrl && ex_taken;
    assign bad_tgt   = tgt_bad(ex_target, PC_W);
    assign br_inc    = active && ex_valid && ex_is_ctrl && (!stall || redirect);
    assign taken_inc = redirect;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drn_nxt   = drn_cnt;
        trap_nxt  = trap;
        flush     = 1'b0;
        fetch_en  = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    fetch_en = !stall && !(halt_req && !redirect);
                    if (redirect) begin
                        flush = 1'b1;
                        if (bad_tgt) begin
                            trap_nxt  = 1'b1;
                            state_nxt = TRAP;
                        end else begin
                            pc_nxt = ex_target[PC_W-1:0];
                        end
                    end else if (stall) begin
                        pc_nxt = pc;
                    end else if (halt_req) begin
                        state_nxt = DRAIN;
                        drn_nxt   = DRN_RELOAD;
                    end else begin
                        pc_nxt = pc + PC_W'(PC_STEP);
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        flush = 1'b1;
                        if (bad_tgt) begin
                            trap_nxt  = 1'b1;
                            state_nxt = TRAP;
                        end else begin
                            // New in-flight instructions follow the redirect, so drain restarts.
                            pc_nxt  = ex_target[PC_W-1:0];
                            drn_nxt = DRN_RELOAD;
                        end
                    end else if (drn_cnt == '0) begin
                        state_nxt = HALTED;
                    end else begin
                        drn_nxt = drn_cnt - 1'b1;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = TRAP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            pc      <= '0;
            drn_cnt <= '0;
            trap    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            drn_cnt <= drn_nxt;
            trap    <= trap_nxt;
        end
    end

    assign flush_if_id = flush;
    assign flush_id_ex = flush;
    assign halted      = (state == HALTED);

    sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (br_inc),
        .count (br_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (taken_inc),
        .count (taken_count)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed plus random checking of branch_redirect_ctrl against a cycle-level behavioural model.
module tb_branch_redirect_ctrl;

    localparam int PC_W      = 9;
    localparam int DRAIN_CYC = 3;
    localparam int CNT_W     = 6;
    localparam int CMAX      = (1 << CNT_W) - 1;
    localparam int MEM_BYTES = 1 << PC_W;

    logic             clk, reset, stall, ex_valid, ex_is_ctrl, ex_taken, halt_req, resume;
    logic [31:0]      ex_target;
    logic [PC_W-1:0]  pc;
    logic             flush_if_id, flush_id_ex, fetch_en, halted, trap;
    logic [CNT_W-1:0] br_count, taken_count;

    branch_redirect_ctrl #(.PC_W(PC_W), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_is_ctrl  (ex_is_ctrl),
        .ex_taken    (ex_taken),
        .ex_target   (ex_target),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc          (pc),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .fetch_en    (fetch_en),
        .halted      (halted),
        .trap        (trap),
        .br_count    (br_count),
        .taken_count (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode flags plus remaining drain cycles.
    int m_pc, m_br, m_tk, m_left;
    bit m_trap, m_halt, m_drain;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic c, input logic t,
                         input logic [31:0] tgt, input logic h, input logic r);
        stall = s; ex_valid = v; ex_is_ctrl = c; ex_taken = t;
        ex_target = tgt; halt_req = h; resume = r;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    // Called at posedge+1 with inputs already driven: checks this cycle, then advances one clock.
    task automatic step();
        bit act, redir, badt, exp_fetch;
        #1;
        act       = !m_trap && !m_halt;
        redir     = act && ex_valid && ex_is_ctrl && ex_taken;
        badt      = (ex_target % 4 != 0) || (ex_target >= MEM_BYTES);
        exp_fetch = act && !m_drain && !stall && !(halt_req && !redir);
        chk("pc",          32'(pc),          32'(m_pc));
        chk("flush_if_id", 32'(flush_if_id), 32'(redir));
        chk("flush_id_ex", 32'(flush_id_ex), 32'(redir));
        chk("fetch_en",    32'(fetch_en),    32'(exp_fetch));
        chk("halted",      32'(halted),      32'(m_halt));
        chk("trap",        32'(trap),        32'(m_trap));
        chk("br_count",    32'(br_count),    32'(m_br));
        chk("taken_count", 32'(taken_count), 32'(m_tk));

        if (act && ex_valid && ex_is_ctrl && (!stall || redir))
            m_br = (m_br == CMAX) ? CMAX : m_br + 1;
        if (redir)
            m_tk = (m_tk == CMAX) ? CMAX : m_tk + 1;
        if (redir && badt) begin
            m_trap = 1; m_drain = 0;
        end else if (redir) begin
            m_pc = ex_target % MEM_BYTES;
            if (m_drain) m_left = DRAIN_CYC - 1;
        end else if (m_drain) begin
            if (m_left == 0) begin
                m_drain = 0; m_halt = 1;
            end else begin
                m_left--;
            end
        end else if (act) begin
            if (stall) begin
            end else if (halt_req) begin
                m_drain = 1; m_left = DRAIN_CYC - 1;
            end else begin
                m_pc = (m_pc + 4) % MEM_BYTES;
            end
        end else if (m_halt && resume) begin
            m_halt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 1, 1, 1, 32'h100, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_pc",       32'(pc),          32'h0);
        chk("rst_fetch_en", 32'(fetch_en),    32'h0);
        chk("rst_flush",    32'(flush_if_id | flush_id_ex), 32'h0);
        chk("rst_halted",   32'(halted),      32'h0);
        chk("rst_trap",     32'(trap),        32'h0);
        chk("rst_br",       32'(br_count),    32'h0);
        chk("rst_taken",    32'(taken_count), 32'h0);
        m_pc = 0; m_br = 0; m_tk = 0; m_left = 0;
        m_trap = 0; m_halt = 0; m_drain = 0;
        idle();
        reset = 1'b0;
    endtask

    initial begin
        logic [PC_W-1:0] frozen;
        logic [31:0]     tgt;
        int              r;

        reset = 1'b1;
        idle();
        #2;
        do_reset();

        // Free-running fetch from 0.
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc", 32'(pc), 32'(i * 4));
            idle(); step();
        end
        for (int i = 0; i < 4; i++) begin idle(); step(); end
        chk("at_0x20", 32'(pc), 32'h20);

        // Taken redirect overrides a simultaneous stall.
        drive(1, 1, 1, 1, 32'h100, 0, 0);
        step();
        chk("redir_pc",    32'(pc),          32'h100);
        chk("redir_br",    32'(br_count),    32'h1);
        chk("redir_taken", 32'(taken_count), 32'h1);

        // Not-taken branch at 0x40.
        do_reset();
        for (int i = 0; i < 16; i++) begin idle(); step(); end
        drive(0, 1, 1, 0, 32'h100, 0, 0);
        step();
        chk("nt_pc",    32'(pc),          32'h44);
        chk("nt_br",    32'(br_count),    32'h1);
        chk("nt_taken", 32'(taken_count), 32'h0);

        // Wrap at top of instruction memory.
        drive(0, 1, 1, 1, 32'h1F8, 0, 0); step();
        idle(); step();
        chk("wrap_pre", 32'(pc), 32'h1FC);
        idle(); step();
        chk("wrap_pc",   32'(pc),   32'h0);
        chk("wrap_trap", 32'(trap), 32'h0);

        // Misaligned and out-of-range targets trap until reset.
        for (int k = 0; k < 2; k++) begin
            tgt = (k == 0) ? 32'h102 : 32'h200;
            for (int i = 0; i < 3; i++) begin idle(); step(); end
            frozen = pc;
            drive(0, 1, 1, 1, tgt, 0, 0); step();
            chk("trap_set", 32'(trap), 32'h1);
            for (int i = 0; i < 3; i++) begin
                drive(0, 1, 1, 1, 32'h40, 0, 1); step();
            end
            chk("trap_pc_frozen", 32'(pc),     32'(frozen));
            chk("trap_halted",    32'(halted), 32'h0);
            do_reset();
            chk("trap_cleared", 32'(trap), 32'h0);
        end

        // Halt drain without interference, then resume.
        for (int i = 0; i < 4; i++) begin idle(); step(); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 32'h0, 1, 0); step();
        end
        chk("halt_done", 32'(halted), 32'h1);
        chk("halt_pc",   32'(pc),     32'h10);
        drive(0, 0, 0, 0, 32'h0, 0, 1); step();
        chk("resume_run", 32'(halted), 32'h0);
        idle(); step();
        chk("resume_pc", 32'(pc), 32'h14);

        // Redirect in the second drain cycle restarts the drain.
        do_reset();
        for (int i = 0; i < 4; i++) begin idle(); step(); end
        drive(0, 0, 0, 0, 32'h0, 1, 0); step();
        drive(0, 0, 0, 0, 32'h0, 1, 0); step();
        drive(0, 1, 1, 1, 32'h80, 1, 0); step();
        chk("drain_redir_pc", 32'(pc), 32'h80);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 32'h0, 1, 0); step();
            chk("drain_restart", 32'(halted), 32'h0);
        end
        drive(0, 0, 0, 0, 32'h0, 1, 0); step();
        chk("drain_halted", 32'(halted), 32'h1);
        drive(0, 0, 0, 0, 32'h0, 0, 1); step();
        idle(); step();
        chk("resume_pc_84", 32'(pc), 32'h84);

        // Resume with halt_req still high re-enters drain after one RUN cycle.
        for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 0, 32'h0, 1, 0); step(); end
        drive(0, 0, 0, 0, 32'h0, 1, 1); step();
        drive(0, 0, 0, 0, 32'h0, 1, 0); step();
        for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 32'h0, 1, 0); step(); end
        chk("rehalt", 32'(halted), 32'h1);

        // Random traffic against the model, including counter saturation.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ((m_trap && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 499) == 0)) begin
                do_reset();
            end
            r = $urandom_range(0, 19);
            if (r == 0)      tgt = $urandom;
            else if (r == 1) tgt = 32'h1FC;
            else             tgt = 32'($urandom_range(0, 127)) << 2;
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 0,
                  tgt,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 4) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Owns the fetch PC register and sequences control-flow changes resolved in EX. Selects the next PC from sequential (PC+4), redirect target, or hold, and asserts flushes of the younger pipeline stages. Also implements halt/drain and the misaligned-target trap, and keeps branch statistics. Sits between the EX-stage branch resolution logic (taken flag plus target) and the IF-stage instruction memory address.

Parameters:
PC_W, 9, width of the fetch PC (byte address; instruction memory is 2^PC_W bytes)
DRAIN_CYC, 3, cycles to hold PC and let in-flight instructions retire after halt_req
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard-unit stall; hold PC
ex_valid  in  1  EX stage holds a valid instruction
ex_is_ctrl  in  1  EX instruction is a branch or jump
ex_taken  in  1  resolved branch-taken / jump select for EX instruction
ex_target  in  32  resolved target address
halt_req  in  1  level request to stop fetching
resume  in  1  pulse; leave HALTED
pc  out  PC_W  current fetch address (registered)
flush_if_id  out  1  kill IF/ID contents (combinational, same cycle as accepted redirect)
flush_id_ex  out  1  kill ID/EX contents (same timing)
fetch_en  out  1  instruction fetch valid this cycle
halted  out  1  state is HALTED
trap  out  1  sticky misaligned/out-of-range target error
br_count  out  CNT_W  resolved control-flow instructions
taken_count  out  CNT_W  taken control-flow instructions

Behaviour:
- Reset (async assert, sync-release assumed upstream): pc=0, state RUN, trap=0, counters=0, all flush=0, fetch_en=0 in the reset cycle, halted=0.
- States: RUN, DRAIN, HALTED, TRAP.
- redirect = ex_valid & ex_is_ctrl & ex_taken, evaluated in RUN and DRAIN only.
- bad_tgt = ex_target[1:0]!=0 or ex_target[31:PC_W]!=0.
- Priority in RUN/DRAIN: bad_tgt redirect > good redirect > stall > halt_req > sequential.
- Good redirect: pc <= ex_target[PC_W-1:0] next edge; flush_if_id=flush_id_ex=1 this cycle. Redirect overrides stall in the same cycle (stalled instruction is younger and is flushed).
- bad_tgt redirect: flushes asserted; pc holds; trap<=1; state -> TRAP. TRAP is left only by reset; fetch_en=0, halted=0.
- stall with no redirect: pc holds, no flush.
- Sequential: pc <= pc+4 modulo 2^PC_W (wraps from 2^PC_W-4 to 0 with no error).
- RUN & halt_req & no redirect/stall: state -> DRAIN, drain counter <= DRAIN_CYC-1, pc holds, fetch_en=0.
- DRAIN: pc holds; counter decrements each cycle; when it is 0, go to HALTED. A good redirect in DRAIN updates pc, flushes, and reloads the counter to DRAIN_CYC-1. halt_req deasserting in DRAIN does not cancel the drain.
- HALTED: halted=1, fetch_en=0, pc holds, ex inputs ignored. resume -> RUN next cycle. resume with halt_req still high -> RUN for one cycle, then DRAIN again.
- fetch_en=1 only in RUN and not stall.
- Counters: br_count increments on ex_valid&ex_is_ctrl in RUN/DRAIN. taken_count increments on redirect, including bad_tgt. Both saturate at all-ones. Neither counter increments while stall=1 unless a redirect occurs.

Decomposition:
- Package branch_ctrl_pkg: enum state_t {RUN, DRAIN, HALTED, TRAP}, constant PC_STEP=4, helper function for the alignment/range check.
- One sub-module: sat_counter (CNT_W, inc, reset, count), instantiated twice.

Test Plan:
- Reset then 4 free cycles -> pc 0,4,8,12; fetch_en=1; counters 0.
- At pc=0x20, EX taken with target 0x100 while stall=1 -> flushes high that cycle, pc=0x100 next cycle, br_count=1, taken_count=1.
- Not-taken branch (ex_taken=0) at pc=0x40 -> no flush, pc=0x44, br_count+1, taken_count unchanged.
- pc=0x1FC sequential -> next pc=0x000, trap stays 0.
- Target 0x102, and separately target 0x200 -> flush, trap=1, state TRAP, pc frozen; only reset clears.
- halt_req at pc=0x10, DRAIN_CYC=3 -> pc holds 0x10, halted=1 after 3 cycles. A taken redirect to 0x80 in the 2nd drain cycle -> pc=0x80 and drain restarts. resume -> pc 0x84 next cycle.
